// File: rtl/cpu_types_pkg.sv
// Shared CPU-side memory types: the RAM handshake state and the native word.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Grant FSM states for the unified-RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2,
    FAULT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Grant-duration watchdog: counts enabled cycles, flags expiry on the LIMIT-th one.
module arb_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = enable && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter for the single-ported unified RAM.
// Define MEM_ARB_TIMEOUT_EN to add a grant watchdog that faults after TIMEOUT_CYCLES.
module mem_arbiter
  import cpu_types_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  arb_state_t state_reg, state_next;
  logic       last_was_d_reg, last_was_d_next;
  logic       err_reg;
  logic       expire;
  logic       d_req, d_done, i_done;

  assign d_req  = dREN | dWEN;
  assign d_done = (state_reg == DGRANT) && (ramstate == ACCESS);
  assign i_done = (state_reg == IGRANT) && (ramstate == ACCESS);

  // ERROR beats everything; a dropped request abandons the grant before ACCESS counts.
  always_comb begin
    state_next      = state_reg;
    last_was_d_next = last_was_d_reg;
    case (state_reg)
      IDLE: begin
        if (d_req && !(last_was_d_reg && iREN)) begin
          state_next = DGRANT;
        end else if (iREN) begin
          state_next      = IGRANT;
          last_was_d_next = 1'b0;
        end
      end
      DGRANT: begin
        if (ramstate == ERROR)       state_next = FAULT;
        else if (!d_req)             state_next = IDLE;
        else if (ramstate == ACCESS) begin
          state_next      = IDLE;
          last_was_d_next = 1'b1;
        end else if (expire)         state_next = FAULT;
      end
      IGRANT: begin
        if (ramstate == ERROR)       state_next = FAULT;
        else if (!iREN)              state_next = IDLE;
        else if (ramstate == ACCESS) state_next = IDLE;
        else if (expire)             state_next = FAULT;
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      last_was_d_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_was_d_reg <= last_was_d_next;
      if (state_next == FAULT) err_reg <= 1'b1;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_reg)
      DGRANT: begin
        ramaddr  = daddr;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramstore = dstore;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      default: ;
    endcase
  end

  assign iwait = iREN & ~i_done;
  assign dwait = d_req & ~d_done;
  assign iload = (i_done && iREN) ? ramload : '0;
  assign dload = (d_done && d_req) ? ramload : '0;
  assign err   = err_reg;

`ifdef MEM_ARB_TIMEOUT_EN
  logic in_grant;
  assign in_grant = (state_reg == DGRANT) || (state_reg == IGRANT);

  arb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (CLK),
    .rst   (RST),
    .clear (state_next != state_reg),
    .enable(in_grant),
    .expire(expire)
  );
`else
  logic unused_timeout;
  assign expire         = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a per-cycle ownership model of the RAM.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [1:0] RS_FREE = 2'd0;
  localparam logic [1:0] RS_BUSY = 2'd1;
  localparam logic [1:0] RS_ACC  = 2'd2;
  localparam logic [1:0] RS_ERR  = 2'd3;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [AW-1:0] iaddr = '0, daddr = '0;
  logic [DW-1:0] dstore = '0, ramload = '0;
  logic [1:0]    ramstate = RS_FREE;
  logic          iwait, dwait, ramREN, ramWEN, err;
  logic [DW-1:0] iload, dload, ramstore;
  logic [AW-1:0] ramaddr;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Model: who owns the RAM (0 nobody, 1 data, 2 fetch, 3 faulted), whether the
  // last completed transaction was data, and how long the current owner has held it.
  int owner = 0;
  bit d_last = 1'b0;
  int age = 0;
  bit model_live = 1'b0;

  always @(negedge CLK) begin
    logic          dreq, d_ok, i_ok, e_ren, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_store;
    int            prev;
    if (RST) begin
      owner = 0; d_last = 1'b0; age = 0; model_live = 1'b1;
    end else if (model_live) begin
      dreq    = dREN | dWEN;
      d_ok    = (owner == 1) && dreq && (ramstate == RS_ACC);
      i_ok    = (owner == 2) && iREN && (ramstate == RS_ACC);
      e_ren   = ((owner == 1) && dREN && !dWEN) || ((owner == 2) && iREN);
      e_wen   = (owner == 1) && dWEN;
      e_addr  = (owner == 1) ? daddr : (owner == 2) ? iaddr : '0;
      e_store = (owner == 1) ? dstore : '0;
      check("cmp_ramREN", ramREN, e_ren);
      check("cmp_ramWEN", ramWEN, e_wen);
      check("cmp_ramaddr", ramaddr, e_addr);
      check("cmp_ramstore", ramstore, e_store);
      check("cmp_iwait", iwait, iREN && !i_ok);
      check("cmp_dwait", dwait, dreq && !d_ok);
      check("cmp_iload", iload, i_ok ? ramload : '0);
      check("cmp_dload", dload, d_ok ? ramload : '0);
      check("cmp_err", err, owner == 3);
      prev = owner;
      case (owner)
        0: begin
          if (dreq && !(d_last && iREN)) owner = 1;
          else if (iREN) begin owner = 2; d_last = 1'b0; end
        end
        1: begin
          if (ramstate == RS_ERR) owner = 3;
          else if (!dreq) owner = 0;
          else if (ramstate == RS_ACC) begin owner = 0; d_last = 1'b1; end
          else if (TIMEOUT_ON && age == TO - 1) owner = 3;
        end
        2: begin
          if (ramstate == RS_ERR) owner = 3;
          else if (!iREN) owner = 0;
          else if (ramstate == RS_ACC) owner = 0;
          else if (TIMEOUT_ON && age == TO - 1) owner = 3;
        end
        default: owner = 3;
      endcase
      if (owner != prev) age = 0;
      else if (owner == 1 || owner == 2) age++;
    end
  end

  initial begin
    int waits, grants;

    // Reset state
    @(negedge CLK);
    check("rst_err", err, 0);
    check("rst_iwait", iwait, 0);
    check("rst_dwait", dwait, 0);
    check("rst_ramREN", ramREN, 0);
    check("rst_ramaddr", ramaddr, 0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // Fetch with two BUSY cycles
    iREN = 1'b1; iaddr = 32'h40; ramstate = RS_BUSY; ramload = 32'h8C22_0004;
    waits = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) ramstate = RS_ACC;
      @(negedge CLK);
      if (iwait) waits++;
      if (c >= 2) check("fetch_ramREN", ramREN, 1);
      if (c == 4) begin
        check("fetch_iload", iload, 32'h8C22_0004);
        check("fetch_iwait_done", iwait, 0);
      end
      tick;
    end
    check("fetch_wait_cycles", waits, 3);
    iREN = 1'b0; ramstate = RS_FREE;
    @(negedge CLK); check("idle_ramREN", ramREN, 0); tick;

    // Write and fetch collide: data first, then fetch, then repeated data read waits
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100;
    dstore = 32'hDEAD_BEEF; ramstate = RS_ACC; ramload = 32'h1234_5678;
    @(negedge CLK); check("col_idle_wen", ramWEN, 0); check("col_idle_dwait", dwait, 1); tick;
    @(negedge CLK);
    check("col_dg_wen", ramWEN, 1);
    check("col_dg_store", ramstore, 32'hDEAD_BEEF);
    check("col_dg_addr", ramaddr, 32'h100);
    check("col_dg_dwait", dwait, 0);
    check("col_dg_iwait", iwait, 1);
    tick;
    dWEN = 1'b0; dREN = 1'b1; daddr = 32'h104; ramload = 32'hCAFE_0001;
    @(negedge CLK); check("col_idle2_dwait", dwait, 1); tick;
    @(negedge CLK);
    check("col_ig_addr", ramaddr, 32'h44);
    check("col_ig_iwait", iwait, 0);
    check("col_ig_dwait", dwait, 1);
    tick;
    iREN = 1'b0;
    @(negedge CLK); check("col_idle3_ren", ramREN, 0); tick;
    @(negedge CLK);
    check("col_dg2_addr", ramaddr, 32'h104);
    check("col_dg2_dload", dload, 32'hCAFE_0001);
    tick;
    dREN = 1'b0;

    // Data read withdrawn after one BUSY cycle
    dREN = 1'b1; daddr = 32'h200; ramstate = RS_BUSY;
    @(negedge CLK); tick;
    @(negedge CLK); check("wd_busy_ren", ramREN, 1); check("wd_busy_dwait", dwait, 1); tick;
    dREN = 1'b0;
    @(negedge CLK); check("wd_drop_ren", ramREN, 0); check("wd_drop_dwait", dwait, 0); tick;
    @(negedge CLK); check("wd_idle_ren", ramREN, 0); tick;
    // last data completion still pending preference: fetch goes first
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h48; daddr = 32'h204; ramstate = RS_ACC;
    @(negedge CLK); tick;
    @(negedge CLK); check("wd_fetch_first", ramaddr, 32'h48); tick;
    iREN = 1'b0;
    @(negedge CLK); tick;
    @(negedge CLK); check("wd_data_addr", ramaddr, 32'h204); check("wd_data_dwait", dwait, 0); tick;
    dREN = 1'b0;

    // ERROR during DGRANT, then asynchronous reset out of FAULT
    dREN = 1'b1; daddr = 32'h300; ramstate = RS_ERR;
    @(negedge CLK); tick;
    @(negedge CLK); tick;
    @(negedge CLK); check("flt_err", err, 1); check("flt_ren", ramREN, 0); check("flt_dwait", dwait, 1); tick;
    dREN = 1'b0; ramstate = RS_FREE;
    @(negedge CLK); check("flt_err_sticky", err, 1); check("flt_dwait_off", dwait, 0); tick;
    iREN = 1'b1;
    @(negedge CLK); check("flt_iwait", iwait, 1);
    #2 RST = 1'b1;
    #1;
    check("arst_err", err, 0);
    check("arst_iwait", iwait, 1);
    check("arst_ren", ramREN, 0);
    @(negedge CLK);
    @(posedge CLK);
    #3 RST = 1'b0; iREN = 1'b0;

    // Data read held BUSY for 100 cycles
    dREN = 1'b1; daddr = 32'h400; ramstate = RS_BUSY;
    grants = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (ramREN) grants++;
      tick;
    end
`ifdef MEM_ARB_TIMEOUT_EN
    check("to_grant_cycles", grants, TO);
    check("to_err", err, 1);
`else
    check("hold_grant_cycles", grants, 99);
    check("hold_dwait", dwait, 1);
    check("hold_err", err, 0);
`endif
    dREN = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
